// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: masked vector / scalar ALU feeding a lock-step pipeline of STAGES registers.
// Lanes and reduced flags are computed at the input; the stage chain only transports them.
module vec_alu_pipe #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic [2:0]              in_op,
  input  logic                    in_vs,
  input  logic [LANES-1:0]        in_mask,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_res,
  output logic [3:0]              out_flags,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_vs,
  output logic                    busy
);
  localparam int VW  = LANES * DATA_W;
  localparam int SHW = $clog2(DATA_W);

  logic [LANES-1:0] laneN_s, laneZ_s, laneC_s, laneV_s, laneAct_s;
  logic [VW-1:0]    headRes_s;
  logic [3:0]       headFlags_s;
  logic             advance_s;

  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [DATA_W-1:0] a_s, b_s, r_s;
    logic [DATA_W:0]   addFull_s, subFull_s;
    logic              c_s, v_s;

    assign a_s       = in_a[i*DATA_W +: DATA_W];
    assign b_s       = in_b[i*DATA_W +: DATA_W];
    assign addFull_s = {1'b0, a_s} + {1'b0, b_s};
    assign subFull_s = {1'b0, a_s} - {1'b0, b_s};

    // Lane ALU: result plus carry (not-borrow for SUB) and signed overflow
    always_comb begin
      r_s = b_s;
      c_s = 1'b0;
      v_s = 1'b0;
      case (in_op)
        3'b000: begin
          r_s = addFull_s[DATA_W-1:0];
          c_s = addFull_s[DATA_W];
          v_s = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (addFull_s[DATA_W-1] != a_s[DATA_W-1]);
        end
        3'b001: begin
          r_s = subFull_s[DATA_W-1:0];
          c_s = ~subFull_s[DATA_W];
          v_s = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (subFull_s[DATA_W-1] != a_s[DATA_W-1]);
        end
        3'b010:  r_s = a_s & b_s;
        3'b011:  r_s = a_s | b_s;
        3'b100:  r_s = a_s ^ b_s;
        3'b101:  r_s = a_s * b_s;
        3'b110:  r_s = a_s << b_s[SHW-1:0];
        3'b111:  r_s = b_s;
        default: r_s = b_s;
      endcase
    end

    // Scalar ops live in the top lane only, regardless of mask
    if (i == LANES - 1) begin : gAct
      assign laneAct_s[i] = in_vs ? in_mask[i] : 1'b1;
    end else begin : gAct
      assign laneAct_s[i] = in_vs & in_mask[i];
    end

    assign laneN_s[i] = r_s[DATA_W-1];
    assign laneZ_s[i] = (r_s == '0);
    assign laneC_s[i] = c_s;
    assign laneV_s[i] = v_s;
    assign headRes_s[i*DATA_W +: DATA_W] = laneAct_s[i] ? r_s : (in_vs ? a_s : '0);
  end

  // Inactive lanes are neutral, so an empty mask yields {0,1,0,0}
  assign headFlags_s = {|(laneN_s & laneAct_s), &(laneZ_s | ~laneAct_s),
                        |(laneC_s & laneAct_s), |(laneV_s & laneAct_s)};

  logic             srcValid_s [STAGES];
  logic [VW-1:0]    srcRes_s   [STAGES];
  logic [3:0]       srcFlags_s [STAGES];
  logic [TAG_W-1:0] srcTag_s   [STAGES];
  logic             srcVs_s    [STAGES];
  logic             stgValid_r [STAGES];
  logic [VW-1:0]    stgRes_r   [STAGES];
  logic [3:0]       stgFlags_r [STAGES];
  logic [TAG_W-1:0] stgTag_r   [STAGES];
  logic             stgVs_r    [STAGES];
  logic [STAGES-1:0] validVec_s;

  assign advance_s = ~stgValid_r[STAGES-1] | out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    if (k == 0) begin : gFeed
      assign srcValid_s[k] = in_valid;
      assign srcRes_s[k]   = headRes_s;
      assign srcFlags_s[k] = headFlags_s;
      assign srcTag_s[k]   = in_tag;
      assign srcVs_s[k]    = in_vs;
    end else begin : gFeed
      assign srcValid_s[k] = stgValid_r[k-1];
      assign srcRes_s[k]   = stgRes_r[k-1];
      assign srcFlags_s[k] = stgFlags_r[k-1];
      assign srcTag_s[k]   = stgTag_r[k-1];
      assign srcVs_s[k]    = stgVs_r[k-1];
    end
    assign validVec_s[k] = stgValid_r[k];

    // Stage register: bubbles included, every stage moves only when the whole pipe advances
    always_ff @(posedge clk) begin
      if (rst) begin
        stgValid_r[k] <= 1'b0;
        stgRes_r[k]   <= '0;
        stgFlags_r[k] <= 4'h0;
        stgTag_r[k]   <= '0;
        stgVs_r[k]    <= 1'b0;
      end else if (advance_s) begin
        stgValid_r[k] <= srcValid_s[k];
        stgRes_r[k]   <= srcRes_s[k];
        stgFlags_r[k] <= srcFlags_s[k];
        stgTag_r[k]   <= srcTag_s[k];
        stgVs_r[k]    <= srcVs_s[k];
      end
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = stgValid_r[STAGES-1];
  assign out_res   = stgRes_r[STAGES-1];
  assign out_flags = stgFlags_r[STAGES-1];
  assign out_tag   = stgTag_r[STAGES-1];
  assign out_vs    = stgVs_r[STAGES-1];
  assign busy      = |validVec_s;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Randomized bench for vec_alu_pipe: arithmetic reference per lane plus a slot-queue
// model of the lock-step pipeline; directed cases cover reset, stall and flag corners.
module tb_vec_alu_pipe #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
);
  localparam int RW    = LANES * DATA_W;
  localparam int CW    = (RW > 32) ? RW : 32;
  localparam int SHMOD = 1 << $clog2(DATA_W);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [RW-1:0]    inA = '0;
  logic [RW-1:0]    inB = '0;
  logic [2:0]       inOp = 3'd0;
  logic             inVs = 1'b0;
  logic [LANES-1:0] inMask = '0;
  logic [TAG_W-1:0] inTag = '0;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [RW-1:0]    outRes;
  logic [3:0]       outFlags;
  logic [TAG_W-1:0] outTag;
  logic             outVs;
  logic             busy;

  vec_alu_pipe #(.LANES(LANES), .DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
    .in_op(inOp), .in_vs(inVs), .in_mask(inMask), .in_tag(inTag), .out_valid(outValid),
    .out_ready(outReady), .out_res(outRes), .out_flags(outFlags), .out_tag(outTag),
    .out_vs(outVs), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [RW-1:0]    res;
    logic [3:0]       fl;
    logic [TAG_W-1:0] tag;
    logic             vs;
  } entry_t;

  entry_t           pipeQ[$];
  logic [TAG_W-1:0] retireQ[$];
  int               assertCnt = 0;
  int               failCnt = 0;
  logic             lastAccepted = 1'b0;

  task automatic checkVal(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic entry_t zeroEntry();
    entry_t z;
    z.v = 1'b0; z.res = '0; z.fl = 4'h0; z.tag = '0; z.vs = 1'b0;
    return z;
  endfunction

  function automatic logic anyValid();
    foreach (pipeQ[i]) if (pipeQ[i].v) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: plain arithmetic per lane, overflow judged against the signed range
  function automatic void refCompute(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                     input logic [2:0] op, input logic vs,
                                     input logic [LANES-1:0] mask,
                                     output logic [RW-1:0] res, output logic [3:0] fl);
    logic [DATA_W-1:0]        la, lb, lr;
    logic [DATA_W+1:0]        ua, ub;
    logic signed [DATA_W+1:0] sa, sb, sw, maxS, minS;
    logic                     c, v, act, rn, rz, rc, rv;
    rn = 1'b0; rz = 1'b1; rc = 1'b0; rv = 1'b0; res = '0;
    maxS = '0; maxS[DATA_W-1] = 1'b1; maxS = maxS - 1; minS = -maxS - 1;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*DATA_W +: DATA_W]; lb = b[i*DATA_W +: DATA_W];
      ua = la; ub = lb; sa = $signed(la); sb = $signed(lb);
      c = 1'b0; v = 1'b0;
      case (op)
        3'd0: begin lr = la + lb; c = ((ua + ub) >> DATA_W) != 0; sw = sa + sb; v = (sw > maxS) || (sw < minS); end
        3'd1: begin lr = la - lb; c = (la >= lb); sw = sa - sb; v = (sw > maxS) || (sw < minS); end
        3'd2: lr = la & lb;
        3'd3: lr = la | lb;
        3'd4: lr = la ^ lb;
        3'd5: lr = la * lb;
        3'd6: lr = la << (lb % SHMOD);
        default: lr = lb;
      endcase
      act = vs ? mask[i] : (i == LANES - 1);
      if (act) begin
        res[i*DATA_W +: DATA_W] = lr;
        rn = rn | lr[DATA_W-1]; rz = rz & (lr == '0); rc = rc | c; rv = rv | v;
      end else begin
        res[i*DATA_W +: DATA_W] = vs ? la : '0;
      end
    end
    fl = {rn, rz, rc, rv};
  endfunction

  // One clock: compare DUT against model head, then let the model advance like the spec says
  task automatic stepCycle();
    entry_t hd, e;
    logic   expReady;
    #1;
    hd = pipeQ[STAGES-1];
    expReady = !hd.v || outReady;
    checkVal("outValid", outValid, hd.v);
    checkVal("inReady", inReady, expReady);
    checkVal("busy", busy, anyValid());
    if (hd.v) begin
      checkVal("outRes", outRes, hd.res);
      checkVal("outFlags", outFlags, hd.fl);
      checkVal("outTag", outTag, hd.tag);
      checkVal("outVs", outVs, hd.vs);
    end
    if (outValid && outReady && !rst) retireQ.push_back(outTag);
    lastAccepted = inValid && expReady && !rst;
    @(posedge clk);
    if (rst) begin
      foreach (pipeQ[i]) pipeQ[i] = zeroEntry();
    end else if (expReady) begin
      e.v = inValid; e.tag = inTag; e.vs = inVs;
      refCompute(inA, inB, inOp, inVs, inMask, e.res, e.fl);
      void'(pipeQ.pop_back());
      pipeQ.push_front(e);
    end
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] randLane();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: begin r = '0; r[DATA_W-1] = 1'b1; return r[DATA_W-1:0]; end
      3: begin r = 64'($urandom_range(0, DATA_W + 2)); return r[DATA_W-1:0]; end
      default: return r[DATA_W-1:0];
    endcase
  endfunction

  task automatic loadOp(input logic [TAG_W-1:0] tag, input logic vec);
    for (int i = 0; i < LANES; i++) begin
      inA[i*DATA_W +: DATA_W] = randLane();
      inB[i*DATA_W +: DATA_W] = randLane();
    end
    for (int i = 0; i < LANES; i++) inMask[i] = $urandom_range(0, 1) == 1;
    inOp = 3'($urandom_range(0, 7));
    inVs = vec;
    inTag = tag;
  endtask

  task automatic runDirected(input string name, input logic [RW-1:0] a, input logic [RW-1:0] b,
                             input logic [2:0] op, input logic vs, input logic [LANES-1:0] mask,
                             input logic [TAG_W-1:0] tag, input logic [RW-1:0] expRes,
                             input logic [3:0] expFl);
    int n;
    rst = 1'b0; outReady = 1'b1; inValid = 1'b1;
    inA = a; inB = b; inOp = op; inVs = vs; inMask = mask; inTag = tag;
    stepCycle();
    inValid = 1'b0;
    n = 1;
    while (!outValid && n < STAGES + 8) begin
      stepCycle();
      n++;
    end
    checkVal({name, "_latency"}, n, STAGES);
    checkVal({name, "_res"}, outRes, expRes);
    checkVal({name, "_flags"}, outFlags, expFl);
    checkVal({name, "_tag"}, outTag, tag);
    checkVal({name, "_vs"}, outVs, vs);
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0]     a, b, expRes;
    logic [DATA_W-1:0] ones, pat;
    logic [7:0]        a5;
    logic [LANES-1:0]  mask;
    int                sent, stallLeft;
    logic              firstSeen;

    for (int i = 0; i < STAGES; i++) pipeQ.push_back(zeroEntry());
    ones = '1; a5 = 8'hA5;
    for (int j = 0; j < DATA_W; j++) pat[j] = a5[j % 8];

    // Reset with an op presented: nothing may be accepted
    loadOp(4'd3, 1'b1);
    rst = 1'b1; inValid = 1'b1;
    @(posedge clk); @(negedge clk);
    stepCycle();
    rst = 1'b0; inValid = 1'b0;
    #1;
    checkVal("rst_outRes", outRes, '0);
    checkVal("rst_outFlags", outFlags, 4'h0);
    checkVal("rst_outTag", outTag, '0);
    checkVal("rst_outVs", outVs, 1'b0);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_inReady", inReady, 1'b1);

    // Vector ADD with carry out of lane 0
    for (int i = 0; i < LANES; i++) begin
      a[i*DATA_W +: DATA_W] = (i == 0) ? ones : DATA_W'(1);
      b[i*DATA_W +: DATA_W] = DATA_W'(1);
      expRes[i*DATA_W +: DATA_W] = (i == 0) ? '0 : DATA_W'(2);
    end
    runDirected("vadd", a, b, 3'd0, 1'b1, '1, 4'd1, expRes, 4'b0010);

    // Scalar SUB going negative; other lanes must be zeroed
    for (int i = 0; i < LANES; i++) begin
      a[i*DATA_W +: DATA_W] = (i == LANES - 1) ? DATA_W'(5) : DATA_W'(i + 3);
      b[i*DATA_W +: DATA_W] = (i == LANES - 1) ? DATA_W'(7) : DATA_W'(i + 9);
      expRes[i*DATA_W +: DATA_W] = (i == LANES - 1) ? ones - DATA_W'(1) : '0;
    end
    for (int i = 0; i < LANES; i++) mask[i] = $urandom_range(0, 1) == 1;
    runDirected("ssub", a, b, 3'd1, 1'b0, mask, 4'd2, expRes, 4'b1000);

    // Vector XOR on the low half of the lanes only
    for (int i = 0; i < LANES; i++) begin
      a[i*DATA_W +: DATA_W] = pat;
      mask[i] = (i < LANES / 2);
      expRes[i*DATA_W +: DATA_W] = (i < LANES / 2) ? '0 : pat;
    end
    runDirected("vxor", a, a, 3'd4, 1'b1, mask, 4'd3, expRes, 4'b0100);

    // Stream of six tagged ops with a three-cycle stall after the first result
    retireQ.delete();
    sent = 0; firstSeen = 1'b0; stallLeft = 0;
    loadOp(TAG_W'(1), 1'b1);
    inValid = 1'b1;
    for (int cyc = 0; cyc < 80 && retireQ.size() < 6; cyc++) begin
      if (outValid && !firstSeen) begin
        firstSeen = 1'b1;
        stallLeft = 3;
      end
      if (stallLeft > 0) begin
        outReady = 1'b0;
        #1;
        checkVal("stall_inReady", inReady, 1'b0);
        stallLeft--;
      end else begin
        outReady = 1'b1;
      end
      stepCycle();
      if (lastAccepted) begin
        sent++;
        if (sent < 6) loadOp(TAG_W'(sent + 1), 1'b1);
        else inValid = 1'b0;
      end
    end
    checkVal("stream_count", retireQ.size(), 6);
    for (int i = 0; i < retireQ.size() && i < 6; i++) checkVal("stream_order", retireQ[i], i + 1);

    // Reset with work in flight: those ops must never come out
    retireQ.delete();
    outReady = 1'b1;
    loadOp(TAG_W'(9), 1'b1);
    inValid = 1'b1;
    stepCycle();
    loadOp(TAG_W'(10), 1'b1);
    rst = 1'b1; outReady = 1'b0;
    stepCycle();
    rst = 1'b0; inValid = 1'b0; outReady = 1'b1;
    #1;
    checkVal("midrst_busy", busy, 1'b0);
    checkVal("midrst_outValid", outValid, 1'b0);
    checkVal("midrst_inReady", inReady, 1'b1);
    for (int i = 0; i < STAGES + 1; i++) stepCycle();
    for (int i = 0; i < LANES; i++) begin
      a[i*DATA_W +: DATA_W] = (i == 0) ? ones : DATA_W'(1);
      b[i*DATA_W +: DATA_W] = DATA_W'(1);
      expRes[i*DATA_W +: DATA_W] = (i == 0) ? '0 : DATA_W'(2);
    end
    runDirected("postrst", a, b, 3'd0, 1'b1, '1, TAG_W'(11), expRes, 4'b0010);
    checkVal("midrst_retired", retireQ.size(), 1);
    if (retireQ.size() > 0) checkVal("midrst_tag", retireQ[0], 11);

    // Random traffic with back-pressure and occasional reset
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!inValid || lastAccepted) begin
        loadOp(TAG_W'($urandom), $urandom_range(0, 3) != 0);
        inValid = $urandom_range(0, 9) < 7;
      end
      outReady = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      stepCycle();
    end
    rst = 1'b0; inValid = 1'b0; outReady = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule

// File: doc/vec_alu_pipe.md
VEC_ALU_PIPE -- requirements
Module: vec_alu_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16, number of 32-bit-class vector lanes (legal 1..32).
REQ-002 SHALL have parameter DATA_W, default 32, lane data width (legal 8..64).
REQ-003 SHALL have parameter STAGES, default 2, pipeline depth in cycles (legal 1..4).
REQ-004 SHALL have parameter TAG_W, default 4, width of destination-register tag.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  operation presented.
REQ-008 in_ready  output  1  pipeline can accept this cycle.
REQ-009 in_a  input  LANES*DATA_W  operand A, lane i at bits [i*DATA_W +: DATA_W].
REQ-010 in_b  input  LANES*DATA_W  operand B, same packing.
REQ-011 in_op  input  3  ALU op code.
REQ-012 in_vs  input  1  1 = vector op, 0 = scalar op (lane LANES-1 only).
REQ-013 in_mask  input  LANES  per-lane enable, vector mode only.
REQ-014 in_tag  input  TAG_W  destination tag, carried unchanged.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_res  output  LANES*DATA_W  lane results.
REQ-018 out_flags  output  4  reduced flags {N,Z,C,V}.
REQ-019 out_tag, out_vs  output  TAG_W, 1  tag and mode of the result.
REQ-020 busy  output  1  any pipeline stage holds a valid entry.

Function
REQ-021 Ops SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 MUL (low DATA_W bits), 110 SLL (a << b[$clog2(DATA_W)-1:0]), 111 PASS b.
REQ-022 Per-lane C SHALL be carry-out for ADD, NOT borrow (a>=b unsigned) for SUB, 0 otherwise; V SHALL be signed overflow for ADD/SUB, 0 otherwise; N = result MSB; Z = result==0.
REQ-023 Active lanes: vector mode = lanes with in_mask=1; scalar mode = lane LANES-1 only, in_mask ignored.
REQ-024 Inactive lanes SHALL output in_a unchanged in vector mode and zero in scalar mode.
REQ-025 Vector reduced flags: N = OR of active N, Z = AND of active Z, C = OR of active C, V = OR of active V; mask all-zero SHALL give {0,1,0,0}.
REQ-026 Scalar reduced flags SHALL equal lane LANES-1 flags.
REQ-027 An op is accepted when in_valid && in_ready; result SHALL appear with out_valid exactly STAGES cycles later if no stall occurs.
REQ-028 Pipeline SHALL advance as one unit: in_ready = !out_valid || out_ready; when out_valid && !out_ready all stages SHALL hold, including bubbles.
REQ-029 out_* SHALL remain stable while out_valid && !out_ready.
REQ-030 Ops SHALL exit in acceptance order; throughput SHALL be one op per cycle under continuous out_ready=1.
REQ-031 Simultaneous accept and output retire SHALL both occur in the same cycle without loss or duplication.
REQ-032 Arithmetic SHALL wrap modulo 2^DATA_W; no lane SHALL affect another lane's result.

Reset
REQ-033 On rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0, busy=0, out_res=0, out_flags=0, out_tag=0, out_vs=0 the following cycle.
REQ-034 rst mid-operation SHALL discard all in-flight ops; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-035 An op presented in a cycle with rst=1 SHALL NOT be accepted.

Verification
REQ-036 Vector ADD, LANES=16, all mask=1, a=0xFFFFFFFF lane 0 others 1, b=1 -> after 2 cycles lane 0 =0, others =2, flags {0,0,1,0}.
REQ-037 Scalar SUB a[15]=5, b[15]=7, other lanes nonzero -> lane 15 =0xFFFFFFFE, lanes 0..14 =0, flags {1,0,0,0}.
REQ-038 Vector XOR mask=0x00FF, a=b=0xA5A5A5A5 -> lanes 0..7 =0, lanes 8..15 =0xA5A5A5A5, flags {0,1,0,0}.
REQ-039 Stream 6 ops with tags 1..6, hold out_ready=0 for 3 cycles after first result -> outputs stable during stall, tags exit 1..6 with none lost or repeated, in_ready=0 while stalled.
REQ-040 Assert rst with 2 ops in flight -> no out_valid for those ops; busy=0 next cycle; new op accepted and returned after STAGES cycles.
REQ-041 Rerun REQ-036/REQ-039 with LANES=4, DATA_W=16, STAGES=1 and STAGES=4 -> identical lane behaviour, latency equal to STAGES.
